id_dual_issue: RTL
==================

// Module: id_dual_issue
// PURPOSE
//  Dual-issue decode-stage holding buffer. Sits directly upstream of the register-forwarding unit.
//  Holds up to two decoded instructions and drives their read addresses to the regfile/forwarding path.
//  Consumes the per-line read-ready and corrected read data, then decides dual, single or no issue into EX.
//  Handles the in-pair RAW hazard: line2 reading line1's destination is held back and re-presented as line1.
// PARAMETERS
//  ADDR_W   5    register address width (32 GPRs, r0 hard-wired zero)
//  DATA_W   32   register data width
//  PC_W     32   program-counter width
//  UOP_W    64   opaque decoded-payload width, passed through untouched
// PORTS   (2-lane buses: lane0 = line1 in low bits, lane1 = line2 in high bits)
//  clk           in   1          clock
//  rst           in   1          asynchronous, active-high reset
//  flush         in   1          pipeline flush (exception/branch redirect), synchronous effect
//  in_valid      in   2          per-lane decoded instruction valid from ID; lane1 never valid without lane0
//  in_ready      out  1          allowin to ID: pair accepted on clk edge when in_valid[0] && in_ready
//  in_pc         in   2*PC_W     lane PCs
//  in_uop        in   2*UOP_W    lane decoded payloads
//  in_raddr1/2   in   2*ADDR_W   lane source addresses
//  in_waddr      in   2*ADDR_W   lane destination address
//  in_we         in   2          lane regfile write enable
//  in_solo       in   2          lane must issue alone in line1 (csr, ertn, ll/sc, barriers)
//  rf_raddr      out  4*ADDR_W   {l2 r2, l2 r1, l1 r2, l1 r1} of the held slots to regfile/forwarding
//  rf_ready      in   2          {line2, line1} read-ready from forwarding unit
//  rf_rdata      in   4*DATA_W   {l2 r2, l2 r1, l1 r2, l1 r1} forwarded operands
//  ex_allowin    in   1          EX can accept this cycle
//  ex_valid      out  2          issued lanes this cycle (combinational)
//  ex_pc/ex_uop  out  2*PC_W / 2*UOP_W  issued payloads, slot-aligned
//  ex_rdata      out  4*DATA_W   issued operands (pass-through of rf_rdata)
// BEHAVIOUR
//  - Two slots S0 (line1), S1 (line2); FSM states EMPTY, PAIR (S0+S1), LONE (S0 only).
//  - Reset: state EMPTY, slots invalid, ex_valid=0, in_ready=0 while rst high, in_ready=1 in first cycle after.
//  - Accept: EMPTY/drain -> PAIR if in_valid==2'b11, LONE if 2'b01.
//  - Latency: captured at edge N, earliest ex_valid in cycle N+1.
//  - hz = S1.raddrX!=0 && S1.raddrX==S0.waddr && S0.we (X=1 or 2).
//  - iss0 = S0 valid && rf_ready[0] && ex_allowin.
//  - iss1 = PAIR && iss0 && rf_ready[1] && !hz && !S0.solo && !S1.solo.
//  - PAIR: iss0&&iss1 -> drained. iss0 only -> S1 promoted to S0, state LONE; its raddrs move to line1 port
//    next cycle. No issue -> hold.
//  - LONE: iss0 -> drained; else hold.
//  - drained: in_ready=1 in the same cycle (combinational allowin); new pair loads on the same edge.
//    No valid input -> EMPTY.
//  - in_ready = EMPTY || (LONE&&iss0) || (PAIR&&iss0&&iss1) and !flush.
//  - Flush: highest priority. ex_valid forced 0 that cycle, next state EMPTY, simultaneous input dropped.
//  - rst mid-operation: all held instructions discarded immediately (async).
//  - rf_raddr for invalid slots driven 0 (never creates false relate); ex_valid[1] implies ex_valid[0].
//  - Order guarantee: S1 never issues before S0; a solo instruction held in S1 issues as line1 after promotion.
// CONFIGURATION
//  ID_ISSUE_PERF_EN defined: adds 32-bit saturating counters perf_dual, perf_single, perf_stall (outputs),
//   incrementing on dual-issue, single-issue, and S0-valid-no-issue cycles; cleared by rst only, not flush.
//  Undefined: the perf outputs are tied 0 and no counter flops exist; all other behaviour identical.
// STRUCTURE
//  - Bus width macros for the 2-lane issue buses are added to the shared header DefineModuleBus.h,
//    alongside the forwarding bus widths; FSM state encodings are localparams.
//  - Sub-module id_pair_hazard: combinational hz/solo check on S0/S1, produces iss1 enable.
// TESTING
//  1. Independent pair (l1 add r4<-r1,r2; l2 add r5<-r6,r7), rf_ready=11, ex_allowin=1
//     -> ex_valid=11 next cycle, in_ready=1.
//  2. In-pair RAW (l1 waddr=r4 we=1; l2 raddr1=r4) -> ex_valid=01, then LONE.
//     The following cycle shows ex_valid=01 with l2's PC and rf_raddr[ADDR_W-1:0]=4.
//  3. rf_ready=10 (line1 waiting on load) for 3 cycles -> ex_valid=00, in_ready=0, slots unchanged.
//     rf_ready=11 -> dual issue.
//  4. l2 solo (csrwr) with no hazard -> ex_valid=01 then 01 (promoted); l1 solo -> same split.
//  5. flush in PAIR with in_valid=11 -> ex_valid=00; next cycle state EMPTY, nothing issued, in_ready=1.
//  6. rst asserted mid-LONE -> ex_valid=0 immediately; with ID_ISSUE_PERF_EN, perf counters read 0.

Source files
------------

// File: rtl/id_dual_issue_pkg.sv
// id_dual_issue_pkg: shared types and constants for the dual-issue decode holding buffer.
//   - FSM state encodings (localparams) and the state enum built from them
//   - performance counter width and a saturating-increment helper
package id_dual_issue_pkg;

  localparam logic [1:0] ST_EMPTY_ENC = 2'd0;
  localparam logic [1:0] ST_PAIR_ENC  = 2'd1;
  localparam logic [1:0] ST_LONE_ENC  = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = ST_EMPTY_ENC,  // no instruction held
    ST_PAIR  = ST_PAIR_ENC,   // S0 (line1) and S1 (line2) held
    ST_LONE  = ST_LONE_ENC    // only S0 held
  } issue_state_e;

  localparam int PERF_W = 32;

  // Increment by one when en is set, sticking at all-ones.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
    logic [PERF_W-1:0] r;
    if (en && (v != {PERF_W{1'b1}})) begin
      r = v + {{(PERF_W-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/id_pair_hazard.sv
// id_pair_hazard: combinational in-pair issue check for the line2 slot.
// Ports:
//   pair_valid   in  both slots hold an instruction
//   iss0         in  line1 issues this cycle
//   line2_ready  in  forwarding unit has line2 operands
//   s1_raddr1/2  in  line2 source registers
//   s0_waddr/we  in  line1 destination and write enable
//   s0_solo/s1_solo in  either instruction must issue alone
//   iss1         out line2 issues alongside line1
module id_pair_hazard #(
  parameter int ADDR_W = 5
) (
  input  logic              pair_valid,
  input  logic              iss0,
  input  logic              line2_ready,
  input  logic [ADDR_W-1:0] s1_raddr1,
  input  logic [ADDR_W-1:0] s1_raddr2,
  input  logic [ADDR_W-1:0] s0_waddr,
  input  logic              s0_we,
  input  logic              s0_solo,
  input  logic              s1_solo,
  output logic              iss1
);

  // r0 reads are constant zero, so they never depend on line1's result.
  function automatic logic src_hit(input logic [ADDR_W-1:0] ra,
                                   input logic [ADDR_W-1:0] wa,
                                   input logic              we);
    return (ra != {ADDR_W{1'b0}}) && (ra == wa) && we;
  endfunction

  logic hz;

  // RAW check between the pair and the resulting line2 issue enable.
  always_comb begin
    hz   = src_hit(s1_raddr1, s0_waddr, s0_we) || src_hit(s1_raddr2, s0_waddr, s0_we);
    iss1 = pair_valid && iss0 && line2_ready && !hz && !s0_solo && !s1_solo;
  end

endmodule

// File: rtl/id_dual_issue.sv
// id_dual_issue: dual-issue decode-stage holding buffer in front of the forwarding unit.
// Holds up to two decoded instructions (S0 = line1, S1 = line2), presents their source
// addresses to the regfile/forwarding path and issues dual, single or none into EX.
// A line2 that reads line1's destination (or any solo instruction) is held and promoted
// to line1 on the following cycle.
// Ports: clk, rst (async active-high), flush; in_* decoded pair from ID with in_ready
// allowin; rf_raddr/rf_ready/rf_rdata to/from forwarding; ex_allowin, ex_valid, ex_pc,
// ex_uop, ex_rdata to EX; perf_dual/perf_single/perf_stall counters.
// Optional feature macro: ID_ISSUE_PERF_EN (counters present; otherwise outputs tied 0).
module id_dual_issue
  import id_dual_issue_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int UOP_W  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [1:0]          in_valid,
  output logic                in_ready,
  input  logic [2*PC_W-1:0]   in_pc,
  input  logic [2*UOP_W-1:0]  in_uop,
  input  logic [2*ADDR_W-1:0] in_raddr1,
  input  logic [2*ADDR_W-1:0] in_raddr2,
  input  logic [2*ADDR_W-1:0] in_waddr,
  input  logic [1:0]          in_we,
  input  logic [1:0]          in_solo,
  output logic [4*ADDR_W-1:0] rf_raddr,
  input  logic [1:0]          rf_ready,
  input  logic [4*DATA_W-1:0] rf_rdata,
  input  logic                ex_allowin,
  output logic [1:0]          ex_valid,
  output logic [2*PC_W-1:0]   ex_pc,
  output logic [2*UOP_W-1:0]  ex_uop,
  output logic [4*DATA_W-1:0] ex_rdata,
  output logic [PERF_W-1:0]   perf_dual,
  output logic [PERF_W-1:0]   perf_single,
  output logic [PERF_W-1:0]   perf_stall
);

  issue_state_e state_q, state_d;

  logic [PC_W-1:0]   pc_q   [2];
  logic [PC_W-1:0]   pc_d   [2];
  logic [UOP_W-1:0]  uop_q  [2];
  logic [UOP_W-1:0]  uop_d  [2];
  logic [ADDR_W-1:0] ra1_q  [2];
  logic [ADDR_W-1:0] ra1_d  [2];
  logic [ADDR_W-1:0] ra2_q  [2];
  logic [ADDR_W-1:0] ra2_d  [2];
  logic [ADDR_W-1:0] wa_q   [2];
  logic [ADDR_W-1:0] wa_d   [2];
  logic [1:0]        we_q, we_d;
  logic [1:0]        solo_q, solo_d;

  logic s0_valid, pair_valid, iss0, iss1, drained, in_accept;

  // Slot status and line1 issue decision; flush suppresses all issue.
  always_comb begin
    s0_valid   = (state_q != ST_EMPTY);
    pair_valid = (state_q == ST_PAIR);
    iss0       = s0_valid && rf_ready[0] && ex_allowin && !flush;
  end

  id_pair_hazard #(.ADDR_W(ADDR_W)) u_hazard (
    .pair_valid  (pair_valid),
    .iss0        (iss0),
    .line2_ready (rf_ready[1]),
    .s1_raddr1   (ra1_q[1]),
    .s1_raddr2   (ra2_q[1]),
    .s0_waddr    (wa_q[0]),
    .s0_we       (we_q[0]),
    .s0_solo     (solo_q[0]),
    .s1_solo     (solo_q[1]),
    .iss1        (iss1)
  );

  // Buffer empties this cycle; rst gates only the allowin output so it never
  // reaches flop data inputs (those are already held by the async reset).
  always_comb begin
    drained   = (state_q == ST_EMPTY) ||
                ((state_q == ST_LONE) && iss0) ||
                ((state_q == ST_PAIR) && iss0 && iss1);
    in_accept = in_valid[0] && drained && !flush;
    in_ready  = drained && !flush && !rst;
  end

  // Next state and slot contents: flush > drain/load > promote S1 > hold.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    solo_d  = solo_q;
    for (int i = 0; i < 2; i++) begin
      pc_d[i]  = pc_q[i];
      uop_d[i] = uop_q[i];
      ra1_d[i] = ra1_q[i];
      ra2_d[i] = ra2_q[i];
      wa_d[i]  = wa_q[i];
    end
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (drained) begin
      if (in_accept) begin
        state_d = in_valid[1] ? ST_PAIR : ST_LONE;
        we_d    = in_we;
        solo_d  = in_solo;
        for (int i = 0; i < 2; i++) begin
          pc_d[i]  = in_pc[i*PC_W +: PC_W];
          uop_d[i] = in_uop[i*UOP_W +: UOP_W];
          ra1_d[i] = in_raddr1[i*ADDR_W +: ADDR_W];
          ra2_d[i] = in_raddr2[i*ADDR_W +: ADDR_W];
          wa_d[i]  = in_waddr[i*ADDR_W +: ADDR_W];
        end
      end else begin
        state_d = ST_EMPTY;
      end
    end else if (pair_valid && iss0) begin
      // line1 left alone: line2 becomes line1 and keeps program order.
      state_d   = ST_LONE;
      pc_d[0]   = pc_q[1];
      uop_d[0]  = uop_q[1];
      ra1_d[0]  = ra1_q[1];
      ra2_d[0]  = ra2_q[1];
      wa_d[0]   = wa_q[1];
      we_d[0]   = we_q[1];
      solo_d[0] = solo_q[1];
    end else begin
      state_d = state_q;
    end
  end

  // State and slot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      we_q    <= 2'b00;
      solo_q  <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        pc_q[i]  <= {PC_W{1'b0}};
        uop_q[i] <= {UOP_W{1'b0}};
        ra1_q[i] <= {ADDR_W{1'b0}};
        ra2_q[i] <= {ADDR_W{1'b0}};
        wa_q[i]  <= {ADDR_W{1'b0}};
      end
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      solo_q  <= solo_d;
      for (int i = 0; i < 2; i++) begin
        pc_q[i]  <= pc_d[i];
        uop_q[i] <= uop_d[i];
        ra1_q[i] <= ra1_d[i];
        ra2_q[i] <= ra2_d[i];
        wa_q[i]  <= wa_d[i];
      end
    end
  end

  // Read addresses of empty slots read as r0 so the forwarding unit sees no false relation.
  always_comb begin
    rf_raddr = {4*ADDR_W{1'b0}};
    if (s0_valid) begin
      rf_raddr[0*ADDR_W +: ADDR_W] = ra1_q[0];
      rf_raddr[1*ADDR_W +: ADDR_W] = ra2_q[0];
    end else begin
      rf_raddr[2*ADDR_W-1:0] = {2*ADDR_W{1'b0}};
    end
    if (pair_valid) begin
      rf_raddr[2*ADDR_W +: ADDR_W] = ra1_q[1];
      rf_raddr[3*ADDR_W +: ADDR_W] = ra2_q[1];
    end else begin
      rf_raddr[4*ADDR_W-1:2*ADDR_W] = {2*ADDR_W{1'b0}};
    end
  end

  // Issue outputs, slot-aligned; operands pass straight through.
  always_comb begin
    ex_valid = {iss1, iss0};
    ex_pc    = {pc_q[1], pc_q[0]};
    ex_uop   = {uop_q[1], uop_q[0]};
    ex_rdata = rf_rdata;
  end

`ifdef ID_ISSUE_PERF_EN
  logic [PERF_W-1:0] perf_dual_q, perf_dual_d;
  logic [PERF_W-1:0] perf_single_q, perf_single_d;
  logic [PERF_W-1:0] perf_stall_q, perf_stall_d;

  // Counter updates; flush cycles with S0 held count as stalls.
  always_comb begin
    perf_dual_d   = sat_inc(perf_dual_q, iss0 && iss1);
    perf_single_d = sat_inc(perf_single_q, iss0 && !iss1);
    perf_stall_d  = sat_inc(perf_stall_q, s0_valid && !iss0);
    perf_dual     = perf_dual_q;
    perf_single   = perf_single_q;
    perf_stall    = perf_stall_q;
  end

  // Counter registers, cleared by reset only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_dual_q   <= {PERF_W{1'b0}};
      perf_single_q <= {PERF_W{1'b0}};
      perf_stall_q  <= {PERF_W{1'b0}};
    end else begin
      perf_dual_q   <= perf_dual_d;
      perf_single_q <= perf_single_d;
      perf_stall_q  <= perf_stall_d;
    end
  end
`else
  // Counters absent.
  always_comb begin
    perf_dual   = {PERF_W{1'b0}};
    perf_single = {PERF_W{1'b0}};
    perf_stall  = {PERF_W{1'b0}};
  end
`endif

endmodule
